// File: rtl/fp_operand_gen.sv
// Operand generator for the FP add/sub unit: fixed, constrained-custom, random and
// special-value streams of (a, b, operation_select) behind a valid/ready handshake.
module fp_operand_gen #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned EXP_BITS       = 8,
  parameter int unsigned MANT_BITS      = 23,
  parameter int unsigned EXP_RAND_BITS  = 2,
  parameter int unsigned MANT_RAND_BITS = 3,
  parameter logic [31:0] SEED           = 32'hACE1_2025
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      num_vectors,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             operation_select,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [1:0] M_FIXED   = 2'd0;
  localparam logic [1:0] M_CUSTOM  = 2'd1;
  localparam logic [1:0] M_RANDOM  = 2'd2;
  localparam logic [1:0] M_SPECIAL = 2'd3;

  localparam logic [31:0] TAPS  = 32'h8020_0003;
  localparam logic [31:0] B_XOR = 32'h5A5A_5A5A;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = (l >> 1) ^ (l[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [WIDTH-1:0] fixed_one();
    logic [WIDTH-1:0] v;
    v = '0;
    v[WIDTH-3 -: EXP_BITS-1] = '1;
    fixed_one = v;
  endfunction

  function automatic logic [WIDTH-1:0] custom_val(input logic [EXP_RAND_BITS-1:0]  r,
                                                  input logic [MANT_RAND_BITS-1:0] m);
    logic [EXP_BITS-1:0]  e;
    logic [MANT_BITS-1:0] f;
    e = '0;
    e[EXP_BITS-1] = 1'b1;
    e[EXP_RAND_BITS-1:0] = r;
    f = '0;
    f[MANT_BITS-1 -: MANT_RAND_BITS] = m;
    custom_val = {1'b0, e, f};
  endfunction

  // LFSR word repeated from the LSB upward, then cut to the FP width
  function automatic logic [WIDTH-1:0] random_val(input logic [31:0] l);
    random_val = WIDTH'({(WIDTH/32+1){l}});
  endfunction

  function automatic logic [WIDTH-1:0] special_val(input logic [2:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    case (idx)
      3'd1: v[WIDTH-1] = 1'b1;
      3'd2: v[WIDTH-3 -: EXP_BITS-1] = '1;
      3'd3: begin
        v[WIDTH-1] = 1'b1;
        v[WIDTH-3 -: EXP_BITS-1] = '1;
      end
      3'd4: v[WIDTH-2 -: EXP_BITS] = '1;
      3'd5: begin
        v[WIDTH-1] = 1'b1;
        v[WIDTH-2 -: EXP_BITS] = '1;
      end
      3'd6: begin
        v[WIDTH-2 -: EXP_BITS] = '1;
        v[MANT_BITS-1] = 1'b1;
      end
      3'd7: v[0] = 1'b1;
      default: v = '0;
    endcase
    special_val = v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      num_q, num_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic [31:0]      lfsr_a_q, lfsr_a_d;
  logic [31:0]      lfsr_b_q, lfsr_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             done_q, done_d;

  logic [1:0]       gen_mode;
  logic [6:0]       gen_k;
  logic [WIDTH-1:0] gen_a, gen_b;
  logic             gen_op;
  logic [15:0]      vc_inc;
  logic [31:0]      seed_eff;

  assign vc_inc   = vec_count_q + 16'd1;
  assign seed_eff = (seed == 32'h0) ? SEED : seed;

  // In IDLE the vector being built is vector 0 of a run starting now; otherwise it is
  // the successor of the one just transferred.
  always_comb begin
    gen_mode = (state_q == S_IDLE) ? mode : mode_q;
    gen_k    = (state_q == S_IDLE) ? 7'd0 : vc_inc[6:0];
    gen_a    = '0;
    gen_b    = '0;
    gen_op   = 1'b0;
    case (gen_mode)
      M_FIXED: begin
        gen_a = fixed_one();
        gen_b = fixed_one();
      end
      M_CUSTOM: begin
        gen_a  = custom_val(lfsr_a_q[EXP_RAND_BITS-1:0], lfsr_a_q[16 +: MANT_RAND_BITS]);
        gen_b  = custom_val(lfsr_b_q[EXP_RAND_BITS-1:0], lfsr_b_q[16 +: MANT_RAND_BITS]);
        gen_op = lfsr_a_q[31];
      end
      M_RANDOM: begin
        gen_a  = random_val(lfsr_a_q);
        gen_b  = random_val(lfsr_b_q);
        gen_op = lfsr_a_q[31] ^ lfsr_b_q[31];
      end
      M_SPECIAL: begin
        gen_a  = special_val(gen_k[2:0]);
        gen_b  = special_val(gen_k[5:3]);
        gen_op = gen_k[6];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    num_d       = num_q;
    vec_count_d = vec_count_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    done_d      = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          lfsr_a_d = seed_eff;
          lfsr_b_d = seed_eff ^ B_XOR;
        end else if (start) begin
          vec_count_d = '0;
          if (num_vectors == 16'd0) begin
            state_d = S_DONE;
          end else begin
            mode_d      = mode;
            num_d       = num_vectors;
            a_d         = gen_a;
            b_d         = gen_b;
            op_d        = gen_op;
            lfsr_a_d    = lfsr_step(lfsr_a_q);
            lfsr_b_d    = lfsr_step(lfsr_b_q);
            out_valid_d = 1'b1;
            state_d     = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        if (out_valid_q && out_ready) begin
          vec_count_d = vc_inc;
          if (vec_count_q == num_q - 16'd1) begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            a_d      = gen_a;
            b_d      = gen_b;
            op_d     = gen_op;
            lfsr_a_d = lfsr_step(lfsr_a_q);
            lfsr_b_d = lfsr_step(lfsr_b_q);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= M_FIXED;
      num_q       <= '0;
      vec_count_q <= '0;
      lfsr_a_q    <= SEED;
      lfsr_b_q    <= SEED ^ B_XOR;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      num_q       <= num_d;
      vec_count_q <= vec_count_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      done_q      <= done_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign a                = a_q;
  assign b                = b_q;
  assign operation_select = op_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign vec_count        = vec_count_q;

endmodule

// File: tb/tb_fp_operand_gen.sv
// Directed checks of fp_operand_gen: fixed, custom, special and random runs, zero-length
// runs, seed handling and asynchronous reset in the middle of a run.
module tb_fp_operand_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_vectors = 16'd0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] a, b;
  logic        operation_select;
  logic        busy, done;
  logic [15:0] vec_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] T [8];
  logic [31:0] la, lb;

  always #5 clk = ~clk;

  fp_operand_gen #(
    .WIDTH(32), .EXP_BITS(8), .MANT_BITS(23),
    .EXP_RAND_BITS(2), .MANT_RAND_BITS(3), .SEED(32'hACE1_2025)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vectors(num_vectors),
    .seed_load(seed_load), .seed(seed), .out_ready(out_ready), .out_valid(out_valid),
    .a(a), .b(b), .operation_select(operation_select), .busy(busy), .done(done),
    .vec_count(vec_count)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] step(input logic [31:0] l);
    logic [31:0] s;
    s = {1'b0, l[31:1]};
    if (l[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  // sign 0, exponent 0x80..0x83 from l[1:0], top mantissa bits from l[18:16]
  function automatic logic [31:0] cust(input logic [31:0] l);
    return 32'h4000_0000 | ({30'b0, l[1:0]} << 23) | ({29'b0, l[18:16]} << 20);
  endfunction

  task automatic rnd_run(input logic [31:0] sd, input logic [31:0] a0, input logic [31:0] b0,
                         input bit poke);
    seed = sd;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("seed_idle", 72'({busy, out_valid}), 72'(0));
    la = (sd == 32'h0) ? 32'hACE1_2025 : sd;
    lb = la ^ 32'h5A5A_5A5A;
    mode = 2'd2; num_vectors = 16'd16; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("rnd_valid", 72'(out_valid), 72'(1));
      chk("rnd_vec", 72'({operation_select, a, b}), 72'({la[31] ^ lb[31], la, lb}));
      if (k == 0) chk("rnd_first", 72'({a, b}), 72'({a0, b0}));
      if (poke && k == 4) begin
        start = 1'b1; seed_load = 1'b1; seed = 32'hDEAD_BEEF;
      end
      tick();
      start = 1'b0; seed_load = 1'b0;
      la = step(la); lb = step(lb);
    end
    chk("rnd_end_valid", 72'(out_valid), 72'(0));
    chk("rnd_count", 72'(vec_count), 72'(16));
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers, cyc;
    bit v, rdy;
    T[0] = 32'h0000_0000; T[1] = 32'h8000_0000; T[2] = 32'h3F80_0000; T[3] = 32'hBF80_0000;
    T[4] = 32'h7F80_0000; T[5] = 32'hFF80_0000; T[6] = 32'h7FC0_0000; T[7] = 32'h0000_0001;

    #1 rst = 1'b1;
    #2;
    chk("rst_outs", 72'({out_valid, a, b, operation_select}), 72'(0));
    chk("rst_ctl", 72'({busy, done, vec_count}), 72'(0));
    tick(); tick();
    rst = 1'b0;
    tick();

    // FIXED, three vectors, consumer always ready
    mode = 2'd0; num_vectors = 16'd3; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("fix_valid", 72'(out_valid), 72'(1));
      chk("fix_vec", 72'({operation_select, a, b}), 72'({1'b0, 32'h3F80_0000, 32'h3F80_0000}));
      chk("fix_count", 72'(vec_count), 72'(k));
      tick();
    end
    chk("fix_end", 72'({out_valid, busy, done}), 72'(3'b010));
    chk("fix_vc", 72'(vec_count), 72'(3));
    tick();
    chk("fix_done", 72'({busy, done}), 72'(2'b01));
    tick();
    chk("fix_done_off", 72'(done), 72'(0));
    chk("fix_vc_hold", 72'(vec_count), 72'(3));

    // zero-length run
    num_vectors = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_c1", 72'({out_valid, busy, done}), 72'(3'b010));
    tick();
    chk("zero_c2", 72'({out_valid, busy, done}), 72'(3'b001));
    tick();
    chk("zero_c3", 72'({out_valid, busy, done}), 72'(3'b000));

    // SPECIAL sweep of all 64 (a,b) pairs
    mode = 2'd3; num_vectors = 16'd64; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk("spc_valid", 72'(out_valid), 72'(1));
      chk("spc_vec", 72'({operation_select, a, b}), 72'({1'b0, T[k % 8], T[k / 8]}));
      if (k == 9) chk("spc_v9", 72'({a, b}), 72'({32'h8000_0000, 32'h8000_0000}));
      tick();
    end
    chk("spc_end", 72'({out_valid, vec_count}), 72'({1'b0, 16'd64}));
    tick(); tick();

    // CUSTOM, 1000 vectors with a randomly stalling consumer
    seed = 32'h1234_5678; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    la = 32'h1234_5678; lb = 32'h486E_0C22;
    mode = 2'd1; num_vectors = 16'd1000; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    xfers = 0; cyc = 0;
    while (xfers < 1000 && cyc < 10000) begin
      out_ready = 1'($urandom_range(0, 1));
      v = out_valid;
      rdy = out_ready;
      chk("cust_valid", 72'(out_valid), 72'(1));
      chk("cust_vec", 72'({operation_select, a, b}), 72'({la[31], cust(la), cust(lb)}));
      tick();
      cyc++;
      if (v && rdy) begin
        xfers++;
        la = step(la); lb = step(lb);
      end
    end
    chk("cust_xfers", 72'(xfers), 72'(1000));
    chk("cust_end", 72'({out_valid, vec_count}), 72'({1'b0, 16'd1000}));
    out_ready = 1'b1;
    tick(); tick();

    // seed_load wins over a simultaneous start
    seed = 32'h1234_5678; seed_load = 1'b1; start = 1'b1; mode = 2'd2; num_vectors = 16'd4;
    tick();
    seed_load = 1'b0; start = 1'b0;
    chk("seed_prio", 72'({out_valid, busy}), 72'(0));
    tick();

    // RANDOM repeatability, and busy-time start/seed_load ignored
    rnd_run(32'h1234_5678, 32'h1234_5678, 32'h486E_0C22, 1'b1);
    rnd_run(32'h1234_5678, 32'h1234_5678, 32'h486E_0C22, 1'b0);
    rnd_run(32'h0, 32'hACE1_2025, 32'hF6BB_7A7F, 1'b0);

    // asynchronous reset mid-run
    mode = 2'd2; num_vectors = 16'd10; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    chk("mid_valid", 72'({out_valid, vec_count}), 72'({1'b1, 16'd2}));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", 72'({out_valid, a, b, operation_select}), 72'(0));
    chk("mid_rst_ctl", 72'({busy, done, vec_count}), 72'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    mode = 2'd2; num_vectors = 16'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_v0", 72'({operation_select, a, b}), 72'({1'b0, 32'hACE1_2025, 32'hF6BB_7A7F}));
    tick();
    chk("post_rst_v1", 72'({operation_select, a, b}), 72'({1'b0, 32'hD650_9011, 32'hFB7D_BD3C}));
    tick();
    chk("post_rst_end", 72'({out_valid, vec_count}), 72'({1'b0, 16'd2}));
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_operand_gen.md
Name: fp_operand_gen

Overview:
Synthesizable, parametrised operand generator for the FP add/sub unit, with a valid/ready handshake. It produces pairs (a, b) plus operation_select in one of four modes: fixed, constrained-custom, full-random and special-value sweep. It emits a programmed number of vectors per run, then signals done. It sits in front of the add/sub datapath in both the testbench and the on-chip self-test wrapper.

Parameters:
WIDTH, 32, total FP word width (sign+exp+mant); WIDTH = 1+EXP_BITS+MANT_BITS
EXP_BITS, 8, exponent field width
MANT_BITS, 23, mantissa field width
EXP_RAND_BITS, 2, random low exponent bits in CUSTOM mode; must be < EXP_BITS-1
MANT_RAND_BITS, 3, random high mantissa bits in CUSTOM mode; must be <= MANT_BITS and <= 16
SEED, 32'hACE1_2025, LFSR reset/default seed; must be non-zero

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin run; sampled only in IDLE
mode  in  2  0=FIXED 1=CUSTOM 2=RANDOM 3=SPECIAL; sampled at start
num_vectors  in  16  vectors per run; sampled at start
seed_load  in  1  load seed into the LFSRs; honoured only in IDLE
seed  in  32  seed value
out_ready  in  1  consumer ready
out_valid  out  1  a/b/operation_select valid
a  out  WIDTH  operand A
b  out  WIDTH  operand B
operation_select  out  1  0=add 1=sub
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of run
vec_count  out  16  vectors transferred in the current run

Behaviour:
- Reset (async, any state, including mid-run): state IDLE; out_valid, a, b, operation_select, busy, done and vec_count all 0; lfsr_a=SEED; lfsr_b=SEED^32'h5A5A_5A5A.
- LFSRs: two 32-bit Galois LFSRs, taps 32'h8020_0003, shift right. Both step once per vector generated.
- seed_load in IDLE: lfsr_a=seed, lfsr_b=seed^32'h5A5A_5A5A. A seed of 0 is replaced by SEED. seed_load has priority over start in the same cycle; start is then ignored. seed_load is ignored while busy.
- FSM states: IDLE, PRESENT, DONE.
- IDLE with start=1 and num_vectors=0: go to DONE. No vector is produced.
- IDLE with start=1 and num_vectors>0: latch mode and num_vectors, clear vec_count, register vector 0, go to PRESENT. out_valid=1 from the following cycle (1-cycle latency).
- PRESENT: a, b and operation_select stay stable while out_valid=1 and out_ready=0.
- Transfer occurs on out_valid && out_ready; vec_count increments.
  - If vec_count (before increment) == num_vectors-1: out_valid=0 and go to DONE.
  - Otherwise: register the next vector on the same edge; out_valid stays 1. Throughput is one vector per cycle.
- DONE: done=1 for exactly one cycle, then IDLE. vec_count holds its final value until the next start.
- start while busy is ignored.
- FIXED mode: a = b = +1.0 = {0, 0, EXP_BITS-1 ones, MANT_BITS zeros} (32'h3F80_0000 at defaults); operation_select=0.
- CUSTOM mode: sign=0; exp = {1, zeros, r}, r = lfsr[EXP_RAND_BITS-1:0]; mant = {m, zeros}, m = lfsr[16+MANT_RAND_BITS-1:16]. a uses lfsr_a, b uses lfsr_b. operation_select=lfsr_a[31].
- RANDOM mode: a = low WIDTH bits of lfsr_a replicated; b likewise from lfsr_b. operation_select = lfsr_a[31]^lfsr_b[31].
- SPECIAL mode: 8-entry table T = {+0, -0, +1.0, -1.0, +inf, -inf, qNaN (exp all ones, mant MSB=1), min denormal (mant=1)}.
  - Vector k: a=T[k%8], b=T[(k/8)%8], operation_select=(k/64)%2. k wraps mod 128.
  - LFSRs still step in this mode.

Test Plan:
- FIXED, num_vectors=3, out_ready=1 -> three consecutive transfers of a=b=32'h3F80_0000, op=0; done pulses 1 cycle after the 3rd transfer; vec_count=3.
- CUSTOM, num_vectors=1000, out_ready random -> every a and b in 32'h4000_0000..32'h41F0_0000 with bits[19:0]=0 and sign=0; a/b stable across every stall; exactly 1000 transfers.
- SPECIAL, num_vectors=64 -> all 64 (a,b) pairs from T appear exactly once with op=0; vector 9 is a=32'h8000_0000, b=32'h8000_0000.
- num_vectors=0 with start -> no out_valid; done pulses 2 cycles after start; busy high for 1 cycle.
- RANDOM, seed_load seed=32'h1234_5678, two identical runs of 16 -> identical sequences. seed=0 reproduces the SEED sequence.
- Assert rst mid-run while out_valid=1 -> outputs 0 immediately (async); the next start after release begins from the SEED sequence.
